// File: rtl/wb_arbiter_if.sv
// ============================================================================
// Module      : wb_arbiter_if
// Description : Source-result and CDB broadcast bundle for wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_arbiter_if #(
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32
);
    logic                 alu_valid_i;
    logic                 mul_valid_i;
    logic                 lsu_valid_i;
    logic                 alu_ready_o;
    logic                 mul_ready_o;
    logic                 lsu_ready_o;
    logic [ROB_IDX_W-1:0] alu_rob_idx_i;
    logic [ROB_IDX_W-1:0] mul_rob_idx_i;
    logic [ROB_IDX_W-1:0] lsu_rob_idx_i;
    logic [4:0]           alu_prd_i;
    logic [4:0]           mul_prd_i;
    logic [4:0]           lsu_prd_i;
    logic [DATA_W-1:0]    alu_value_i;
    logic [DATA_W-1:0]    mul_value_i;
    logic [DATA_W-1:0]    lsu_value_i;

    logic                 cdb_valid_o;
    logic                 cdb_ready_i;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_o;
    logic [4:0]           cdb_prd_o;
    logic [DATA_W-1:0]    cdb_data_o;
    logic [1:0]           cdb_src_o;
    logic                 busy_o;

    // Arbiter side: consumes source results, drives the broadcast.
    modport master (
        input  alu_valid_i, mul_valid_i, lsu_valid_i,
        output alu_ready_o, mul_ready_o, lsu_ready_o,
        input  alu_rob_idx_i, mul_rob_idx_i, lsu_rob_idx_i,
        input  alu_prd_i, mul_prd_i, lsu_prd_i,
        input  alu_value_i, mul_value_i, lsu_value_i,
        output cdb_valid_o,
        input  cdb_ready_i,
        output cdb_rob_idx_o, cdb_prd_o, cdb_data_o, cdb_src_o,
        output busy_o
    );

    modport slave (
        output alu_valid_i, mul_valid_i, lsu_valid_i,
        input  alu_ready_o, mul_ready_o, lsu_ready_o,
        output alu_rob_idx_i, mul_rob_idx_i, lsu_rob_idx_i,
        output alu_prd_i, mul_prd_i, lsu_prd_i,
        output alu_value_i, mul_value_i, lsu_value_i,
        input  cdb_valid_o,
        output cdb_ready_i,
        input  cdb_rob_idx_o, cdb_prd_o, cdb_data_o, cdb_src_o,
        input  busy_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Three-source writeback arbiter: per-source FIFOs feeding a
//               round-robin granted, registered CDB broadcast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_IDX_W  = 5,
    parameter int DATA_W     = 32
) (
    input  wire logic      clk_i,
    input  wire logic      reset_i,
    input  wire logic      flush_i,
    wb_arbiter_if.master   bus
);

    localparam int c_ENTRY_W = ROB_IDX_W + 5 + DATA_W;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_SRC_ALU = 2'd0;
    localparam logic [1:0] c_SRC_MUL = 2'd1;
    localparam logic [1:0] c_SRC_LSU = 2'd2;

    logic [2:0]           w_in_valid;
    logic [2:0]           w_ready;
    logic [2:0]           w_push;
    logic [2:0]           w_pop;
    logic [2:0]           w_nonempty;
    logic [c_ENTRY_W-1:0] w_in_data [3];
    logic [c_ENTRY_W-1:0] w_head    [3];

    logic                 r_cdb_valid;
    logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
    logic [4:0]           r_cdb_prd;
    logic [DATA_W-1:0]    r_cdb_data;
    logic [1:0]           r_cdb_src;
    logic [1:0]           r_rr;

    logic                 w_load;
    logic                 w_grant_valid;
    logic [1:0]           w_grant_src;
    logic [1:0]           w_cand1;
    logic [1:0]           w_cand2;
    logic [1:0]           w_next_rr;

    assign w_in_valid = {bus.lsu_valid_i, bus.mul_valid_i, bus.alu_valid_i};
    assign w_in_data[0] = {bus.alu_rob_idx_i, bus.alu_prd_i, bus.alu_value_i};
    assign w_in_data[1] = {bus.mul_rob_idx_i, bus.mul_prd_i, bus.mul_value_i};
    assign w_in_data[2] = {bus.lsu_rob_idx_i, bus.lsu_prd_i, bus.lsu_value_i};

    assign bus.alu_ready_o = w_ready[0];
    assign bus.mul_ready_o = w_ready[1];
    assign bus.lsu_ready_o = w_ready[2];

    generate
        for (genvar s = 0; s < 3; s++) begin : g_src
            logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
            logic [c_PTR_W-1:0]   r_rd;
            logic [c_PTR_W-1:0]   r_wr;
            logic [c_CNT_W-1:0]   r_count;

            // Ready looks only at the stored count so it never loops back
            // through cdb_ready_i; reset forces it low.
            assign w_nonempty[s] = (r_count != '0);
            assign w_ready[s]    = !reset_i && (r_count < c_DEPTH);
            assign w_push[s]     = w_in_valid[s] && w_ready[s];
            assign w_head[s]     = r_mem[r_rd];

            always_ff @(posedge clk_i) begin
                if (w_push[s] && !flush_i) begin
                    r_mem[r_wr] <= w_in_data[s];
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i || flush_i) begin
                    r_rd    <= '0;
                    r_wr    <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[s]) begin
                        r_wr <= r_wr + 1'b1;
                    end
                    if (w_pop[s]) begin
                        r_rd <= r_rd + 1'b1;
                    end
                    case ({w_push[s], w_pop[s]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    assign w_load = !r_cdb_valid || bus.cdb_ready_i;

    // Search order starts at r_rr and walks ALU->MUL->LSU cyclically.
    always_comb begin
        w_cand1       = (r_rr == c_SRC_LSU) ? c_SRC_ALU : r_rr + 2'd1;
        w_cand2       = (r_rr == c_SRC_ALU) ? c_SRC_LSU : r_rr - 2'd1;
        w_grant_valid = 1'b1;
        w_grant_src   = r_rr;
        if (w_nonempty[r_rr]) begin
            w_grant_src = r_rr;
        end else if (w_nonempty[w_cand1]) begin
            w_grant_src = w_cand1;
        end else if (w_nonempty[w_cand2]) begin
            w_grant_src = w_cand2;
        end else begin
            w_grant_valid = 1'b0;
        end
    end

    assign w_next_rr = (w_grant_src == c_SRC_LSU) ? c_SRC_ALU : w_grant_src + 2'd1;
    assign w_pop     = (w_load && w_grant_valid) ? (3'b001 << w_grant_src) : 3'b000;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cdb_valid   <= 1'b0;
            r_cdb_rob_idx <= '0;
            r_cdb_prd     <= '0;
            r_cdb_data    <= '0;
            r_cdb_src     <= c_SRC_ALU;
            r_rr          <= c_SRC_ALU;
        end else if (flush_i) begin
            r_cdb_valid <= 1'b0;
            r_rr        <= c_SRC_ALU;
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_cdb_valid                             <= 1'b1;
                {r_cdb_rob_idx, r_cdb_prd, r_cdb_data}  <= w_head[w_grant_src];
                r_cdb_src                               <= w_grant_src;
                r_rr                                    <= w_next_rr;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign bus.cdb_valid_o   = r_cdb_valid;
    assign bus.cdb_rob_idx_o = r_cdb_rob_idx;
    assign bus.cdb_prd_o     = r_cdb_prd;
    assign bus.cdb_data_o    = r_cdb_data;
    assign bus.cdb_src_o     = r_cdb_src;
    assign bus.busy_o        = !reset_i && ((|w_nonempty) || r_cdb_valid);

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: entries per source queue; legal values are 2 or 4.
REQ-002 Parameter ROB_IDX_W, default 5: ROB index width.
REQ-003 Parameter DATA_W, default 32: result width.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 flush_i  input  1  synchronous discard of all queued and presented results.
REQ-007 alu_valid_i / mul_valid_i / lsu_valid_i  input  1 each  source result valid.
REQ-008 alu_ready_o / mul_ready_o / lsu_ready_o  output  1 each  source queue can accept.
REQ-009 {alu,mul,lsu}_rob_idx_i  input  ROB_IDX_W  ROB entry of the result.
REQ-010 {alu,mul,lsu}_prd_i  input  5  physical destination register.
REQ-011 {alu,mul,lsu}_value_i  input  DATA_W  result value.
REQ-012 cdb_valid_o  output  1  broadcast valid toward ROB/rename/RS.
REQ-013 cdb_ready_i  input  1  consumer accepts the broadcast.
REQ-014 cdb_rob_idx_o  output  ROB_IDX_W; cdb_prd_o  output  5; cdb_data_o  output  DATA_W; all are broadcast payload.
REQ-015 cdb_src_o  output  2  granted source: 00 ALU, 01 MUL, 10 LSU; 11 is never driven.
REQ-016 busy_o  output  1  asserted when any queue is non-empty or cdb_valid_o is high.

Function
REQ-017 Each source has its own FIFO of FIFO_DEPTH entries, holding {rob_idx, prd, value}, with a wrap-around read pointer, write pointer and count.
REQ-018 {src}_ready_o is high when the count is below FIFO_DEPTH; it is derived from registered count only and never from cdb_ready_i or the same-cycle pop.
REQ-019 A push occurs at a rising edge where valid_i and ready_o are both high; valid_i with ready_o low is ignored, and the source must hold its result.
REQ-020 A push and a pop on the same queue in one edge leave the count unchanged and preserve data order.
REQ-021 Results from one source leave in the same order they were accepted.
REQ-022 The output register loads when cdb_valid_o is low or when cdb_valid_o and cdb_ready_i are both high (a handshake).
REQ-023 On a load, the arbiter grants one non-empty queue head by round-robin from rr_ptr, in cyclic order ALU->MUL->LSU; that head is popped and latched into the cdb_* outputs with cdb_valid_o=1.
REQ-024 After each grant, rr_ptr = (granted source + 1) mod 3; with no grant, rr_ptr is unchanged.
REQ-025 If the output register loads and all queues are empty, cdb_valid_o goes to 0 and the payload holds its last value.
REQ-026 While cdb_valid_o is high and cdb_ready_i is low, all cdb_* outputs stay stable and no pop occurs.
REQ-027 Latency: a result pushed at edge k into an empty queue, with the output free or handshaking at edge k+1 and its source winning arbitration, appears on cdb_valid_o after edge k+1.
REQ-028 Sustained throughput is one broadcast per cycle while cdb_ready_i=1 and any queue is non-empty.
REQ-029 flush_i=1 at an edge zeroes all counts and pointers, clears cdb_valid_o and sets rr_ptr=ALU.
REQ-030 Flush discards any same-edge push and pop, and has priority over every other event except reset_i.
REQ-031 Counts never exceed FIFO_DEPTH and never underflow; a pop is only ever issued for a non-empty head.

Reset
REQ-032 reset_i=1 at an edge clears all counts, pointers and cdb_valid_o, sets cdb_rob_idx_o, cdb_prd_o, cdb_data_o and cdb_src_o to 0, and sets rr_ptr=ALU.
REQ-033 While reset_i is high, all {src}_ready_o are 0 and busy_o is 0; in the first cycle after reset deasserts, all ready_o are 1.
REQ-034 Reset asserted mid-operation discards all queued results; no broadcast is emitted in the cycle following the reset edge.

Verification
REQ-035 Single ALU result: rob_idx=3, prd=9, value=0xDEADBEEF pushed at edge k, cdb_ready_i=1 -> after edge k+1, cdb_valid_o=1, src=00, rob_idx=3, prd=9, data=0xDEADBEEF for exactly one cycle.
REQ-036 Simultaneous push from ALU, MUL and LSU with rr_ptr=ALU and cdb_ready_i=1 -> three consecutive broadcasts in order ALU, MUL, LSU; busy_o falls after the third.
REQ-037 Backpressure: cdb_ready_i=0 with continuous MUL pushes at FIFO_DEPTH=2 -> one result held on cdb, two queued, mul_ready_o=0, payload stable; raising cdb_ready_i drains all three in order.
REQ-038 Fairness: ALU and LSU both always valid with cdb_ready_i=1 -> grants alternate ALU, LSU, ALU, LSU; MUL is never granted while empty.
REQ-039 Flush with 2 queued LSU results and cdb_valid_o=1 -> next cycle cdb_valid_o=0, busy_o=0, all ready_o=1; a push in the flush cycle is lost.
REQ-040 reset_i asserted for one cycle while queues are non-empty -> all outputs 0 next cycle, ready_o=1 the cycle after.
